// File: rtl/time_adjust_ctrl.sv
// time_adjust_ctrl: conditions the four time-setting buttons and turns them
// into single-cycle minute/hour inc/dec pulses that never collide with the
// counters' own carry pulses.

// Per-button input path: 2-flop synchronizer followed by a stable-level debouncer.
module time_adjust_deb #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_deb
);
  logic          r_sync1, r_sync2, r_deb;
  logic [CW-1:0] r_cnt;

  // Synchronize, then accept the synced level once it has differed from the
  // debounced level for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb = r_deb;
endmodule

// Per-group (minute or hour) hold/repeat FSM plus the single pending-pulse slot.
module time_adjust_grp #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int TW            = 25
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_add,
  input  logic i_red,
  input  logic i_carry,
  output logic o_inc,
  output logic o_dec,
  output logic o_pend
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_held_add;
  logic          r_pend_inc, r_pend_dec;
  logic          w_rel, w_req, w_req_add;

  // Request decision for this cycle: a fresh single press, or a timer expiry
  // while the same button stays held alone.
  always_comb begin
    w_rel     = (i_add & i_red) | (r_held_add ? ~i_add : ~i_red);
    w_req     = 1'b0;
    w_req_add = r_held_add;
    case (r_state)
      S_IDLE: begin
        w_req     = i_add ^ i_red;
        w_req_add = i_add;
      end
      S_HOLD, S_REPEAT: w_req = ~w_rel & (r_timer == TW'(1));
      default: w_req = 1'b0;
    endcase
  end

  // FSM, repeat timer and pending slot; release wins over a coincident expiry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_held_add <= 1'b0;
      r_pend_inc <= 1'b0;
      r_pend_dec <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (i_add ^ i_red) begin
            r_state    <= S_HOLD;
            r_timer    <= TW'(REPEAT_DELAY);
            r_held_add <= i_add;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (w_rel) begin
            r_state <= S_IDLE;
            r_timer <= '0;
          end else if (r_timer == TW'(1)) begin
            r_state <= S_REPEAT;
            r_timer <= TW'(REPEAT_PERIOD);
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
        end
      endcase

      // One outstanding pulse: it drains on the first carry-free cycle, and any
      // request arriving while it is outstanding is merged into it.
      if (r_pend_inc | r_pend_dec) begin
        if (!i_carry) begin
          r_pend_inc <= 1'b0;
          r_pend_dec <= 1'b0;
        end
      end else if (w_req) begin
        r_pend_inc <= w_req_add;
        r_pend_dec <= ~w_req_add;
      end
    end
  end

  // The pending flop is masked by the live carry so the counter never sees a
  // user adjust and a carry in the same cycle.
  assign o_inc  = r_pend_inc & ~i_carry;
  assign o_dec  = r_pend_dec & ~i_carry;
  assign o_pend = r_pend_inc | r_pend_dec;
endmodule

module time_adjust_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_min_add,
  input  logic       i_min_reduce,
  input  logic       i_hour_add,
  input  logic       i_hour_reduce,
  input  logic       i_sec_carry,
  input  logic       i_min_carry,
  output logic       o_min_inc,
  output logic       o_min_dec,
  output logic       o_hour_inc,
  output logic       o_hour_dec,
  output logic [3:0] o_btn_state,
  output logic       o_adj_active
);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  logic [3:0] w_raw, w_deb;
  logic [1:0] w_inc, w_dec, w_pend;

  assign w_raw = {i_hour_reduce, i_hour_add, i_min_reduce, i_min_add};

  time_adjust_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb[3:0] (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_raw   (w_raw),
    .o_deb   (w_deb)
  );

  // Index 0 = minute group (sec_carry), index 1 = hour group (min_carry).
  time_adjust_grp #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .TW            (TW)
  ) u_grp[1:0] (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_add   ({w_deb[2], w_deb[0]}),
    .i_red   ({w_deb[3], w_deb[1]}),
    .i_carry ({i_min_carry, i_sec_carry}),
    .o_inc   (w_inc),
    .o_dec   (w_dec),
    .o_pend  (w_pend)
  );

  assign o_min_inc    = w_inc[0];
  assign o_min_dec    = w_dec[0];
  assign o_hour_inc   = w_inc[1];
  assign o_hour_dec   = w_dec[1];
  assign o_btn_state  = w_deb;
  assign o_adj_active = (|w_deb) | (|w_pend);
endmodule
